// File: rtl/spc7110_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : spc7110_alu_seq
// Brief    : Bit-serial multiply/divide ALU behind a byte-wide register window
// Revision : 1.0 - initial release
// ============================================================================
module spc7110_alu_seq #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          EN,
  input  logic [AW-1:0] ADDR,
  input  logic          RD,
  input  logic          WR,
  input  logic [7:0]    DIN,
  output logic [7:0]    DOUT,
  output logic          BUSY,
  output logic          DONE
);

  localparam int c_NA       = W / 4;
  localparam int c_NB       = W / 8;
  localparam int c_A_BASE   = 0;
  localparam int c_MUL_BASE = c_NA;
  localparam int c_DIV_BASE = c_NA + c_NB;
  localparam int c_RES_BASE = c_NA + 2 * c_NB;
  localparam int c_REM_BASE = 2 * c_NA + 2 * c_NB;
  localparam int c_CTRL     = 2 * c_NA + 3 * c_NB;
  localparam int c_STAT     = c_CTRL + 1;
  localparam int c_CW       = $clog2(2 * W);

  localparam logic [c_CW-1:0] c_CNT_MUL = c_CW'(W - 1);
  localparam logic [c_CW-1:0] c_CNT_DIV = c_CW'(2 * W - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIX  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2*W-1:0] r_a, r_res, r_op_a;
  logic [W-1:0]   r_mul, r_div, r_rem, r_op_b, r_part;
  logic [c_CW-1:0] r_cnt;
  logic           r_mode, r_dz, r_done, r_is_div, r_signed, r_neg_q, r_neg_r, r_dz_op;
  logic [7:0]     r_dout, w_rd_data;

  logic           w_wr, w_rd, w_ctrl_wr, w_start_mul, w_start_div, w_last, w_finish;
  logic [W-1:0]   w_mul_new, w_div_new;
  logic [W:0]     w_mul_sum, w_div_sh;
  logic [W-1:0]   w_mul_hi_n, w_mul_lo_n, w_div_rem_n, w_div_diff;
  logic           w_div_ge;
  logic [2*W-1:0] w_div_q_n, w_a_mag, w_prod, w_res_fin;
  logic [W-1:0]   w_a_lo_mag, w_b_mag, w_rem_fin;

  assign w_wr        = EN & WR;
  assign w_rd        = EN & RD;
  assign w_ctrl_wr   = w_wr && (ADDR == AW'(c_CTRL));
  assign w_start_mul = w_wr && (ADDR == AW'(c_MUL_BASE + c_NB - 1));
  assign w_start_div = w_wr && (ADDR == AW'(c_DIV_BASE + c_NB - 1));
  assign w_last      = (r_cnt == '0);

  assign BUSY = (r_state != S_IDLE);
  assign DONE = r_done;
  assign DOUT = r_dout;

  // Operand as it will look once the top byte being written lands.
  always_comb begin
    w_mul_new           = r_mul;
    w_mul_new[W-1 -: 8] = DIN;
    w_div_new           = r_div;
    w_div_new[W-1 -: 8] = DIN;
  end

  // Staging registers and mode
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a    <= '0;
      r_mul  <= '0;
      r_div  <= '0;
      r_mode <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_a    <= '0;
      r_mul  <= '0;
      r_div  <= '0;
      r_mode <= DIN[0];
    end else if (w_wr) begin
      for (int i = 0; i < c_NA; i++)
        if (ADDR == AW'(c_A_BASE + i)) r_a[8*i +: 8] <= DIN;
      for (int i = 0; i < c_NB; i++) begin
        if (ADDR == AW'(c_MUL_BASE + i)) r_mul[8*i +: 8] <= DIN;
        if (ADDR == AW'(c_DIV_BASE + i)) r_div[8*i +: 8] <= DIN;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < c_NA; i++) begin
      if (ADDR == AW'(c_A_BASE + i))   w_rd_data = r_a[8*i +: 8];
      if (ADDR == AW'(c_RES_BASE + i)) w_rd_data = r_res[8*i +: 8];
    end
    for (int i = 0; i < c_NB; i++) begin
      if (ADDR == AW'(c_MUL_BASE + i)) w_rd_data = r_mul[8*i +: 8];
      if (ADDR == AW'(c_DIV_BASE + i)) w_rd_data = r_div[8*i +: 8];
      if (ADDR == AW'(c_REM_BASE + i)) w_rd_data = r_rem[8*i +: 8];
    end
    if (ADDR == AW'(c_CTRL)) w_rd_data = {7'b0, r_mode};
    if (ADDR == AW'(c_STAT)) w_rd_data = {BUSY, 5'b0, r_dz, r_mode};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  r_dout <= '0;
    else if (w_rd) r_dout <= w_rd_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Start and CTRL writes take priority over a completion on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    if (w_ctrl_wr) begin
      w_state_nxt = S_IDLE;
    end else if (w_start_mul) begin
      w_state_nxt = r_mode ? S_PREP : S_MUL;
    end else if (w_start_div) begin
      if (w_div_new == '0) w_state_nxt = S_FIX;
      else                 w_state_nxt = r_mode ? S_PREP : S_DIV;
    end else begin
      case (r_state)
        S_PREP: w_state_nxt = r_is_div ? S_DIV : S_MUL;
        S_MUL, S_DIV: begin
          if (w_last) begin
            w_state_nxt = r_signed ? S_FIX : S_IDLE;
            w_finish    = !r_signed;
          end
        end
        S_FIX: begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // One shift-add / restoring-subtract step
  assign w_mul_sum   = {1'b0, r_part} + (r_op_a[0] ? {1'b0, r_op_b} : {(W+1){1'b0}});
  assign w_mul_hi_n  = w_mul_sum[W:1];
  assign w_mul_lo_n  = {w_mul_sum[0], r_op_a[W-1:1]};
  assign w_div_sh    = {r_part, r_op_a[2*W-1]};
  assign w_div_ge    = (w_div_sh >= {1'b0, r_op_b});
  assign w_div_diff  = w_div_sh[W-1:0] - r_op_b;
  assign w_div_rem_n = w_div_ge ? w_div_diff : w_div_sh[W-1:0];
  assign w_div_q_n   = {r_op_a[2*W-2:0], w_div_ge};

  assign w_a_mag    = r_op_a[2*W-1] ? -r_op_a : r_op_a;
  assign w_a_lo_mag = r_op_a[W-1] ? -r_op_a[W-1:0] : r_op_a[W-1:0];
  assign w_b_mag    = r_op_b[W-1] ? -r_op_b : r_op_b;
  assign w_prod     = {r_part, r_op_a[W-1:0]};

  always_comb begin
    w_res_fin = '0;
    w_rem_fin = '0;
    case (r_state)
      S_MUL: w_res_fin = {w_mul_hi_n, w_mul_lo_n};
      S_DIV: begin
        w_res_fin = w_div_q_n;
        w_rem_fin = w_div_rem_n;
      end
      S_FIX: begin
        if (r_dz_op) begin
          w_rem_fin = r_op_a[W-1:0];
        end else if (!r_is_div) begin
          w_res_fin = r_neg_q ? -w_prod : w_prod;
        end else begin
          w_res_fin = r_neg_q ? -r_op_a : r_op_a;
          w_rem_fin = r_neg_r ? -r_part : r_part;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_res    <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_part   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz_op  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ctrl_wr) begin
        r_res <= '0;
        r_rem <= '0;
        r_dz  <= 1'b0;
      end else if (w_start_mul || w_start_div) begin
        r_is_div <= w_start_div;
        r_signed <= r_mode;
        r_dz_op  <= w_start_div && (w_div_new == '0);
        r_op_a   <= w_start_div ? r_a : {{W{1'b0}}, r_a[W-1:0]};
        r_op_b   <= w_start_div ? w_div_new : w_mul_new;
        r_part   <= '0;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
        r_cnt    <= w_start_div ? c_CNT_DIV : c_CNT_MUL;
      end else begin
        case (r_state)
          S_PREP: begin
            r_op_b <= w_b_mag;
            if (r_is_div) begin
              r_op_a  <= w_a_mag;
              r_neg_q <= r_op_a[2*W-1] ^ r_op_b[W-1];
              r_neg_r <= r_op_a[2*W-1];
            end else begin
              r_op_a  <= {{W{1'b0}}, w_a_lo_mag};
              r_neg_q <= r_op_a[W-1] ^ r_op_b[W-1];
            end
          end
          S_MUL: begin
            r_part         <= w_mul_hi_n;
            r_op_a[W-1:0]  <= w_mul_lo_n;
            r_cnt          <= r_cnt - c_CNT_ONE;
          end
          S_DIV: begin
            r_part <= w_div_rem_n;
            r_op_a <= w_div_q_n;
            r_cnt  <= r_cnt - c_CNT_ONE;
          end
          default: ;
        endcase
        if (w_finish) begin
          r_res  <= w_res_fin;
          r_rem  <= w_rem_fin;
          r_done <= 1'b1;
          if (r_is_div) r_dz <= r_dz_op;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spc7110_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spc7110_alu_seq
// Brief    : Randomized bench for spc7110_alu_seq against an arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
module tb_spc7110_alu_seq;

  localparam int W  = 16;
  localparam int AW = 5;   // one spare address bit so unmapped reads exist

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          EN = 1'b0, RD = 1'b0, WR = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic [7:0]    DIN = '0;
  logic [7:0]    DOUT;
  logic          BUSY, DONE;

  int          n_tests = 0, n_fail = 0, n_done = 0;
  bit          m_mode = 1'b0, m_dz = 1'b0;
  logic [31:0] m_res = '0;

  spc7110_alu_seq #(.W(W), .AW(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .ADDR(ADDR), .RD(RD), .WR(WR),
    .DIN(DIN), .DOUT(DOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (DONE) n_done++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input int a, input logic [7:0] d);
    @(negedge CLK);
    EN = 1'b1; WR = 1'b1; RD = 1'b0; ADDR = AW'(a); DIN = d;
    @(posedge CLK); #1;
    EN = 1'b0; WR = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [7:0] d);
    @(negedge CLK);
    EN = 1'b1; RD = 1'b1; WR = 1'b0; ADDR = AW'(a);
    @(posedge CLK); #1;
    EN = 1'b0; RD = 1'b0;
    d = DOUT;
  endtask

  task automatic rd_bytes(input int base, input int n, output logic [31:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      bus_rd(base + i, b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (BUSY && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("busy_end", 32'(BUSY), 32'd0);
  endtask

  task automatic set_mode(input bit mode);
    bus_wr(14, {7'b0, mode});
    m_mode = mode;
    m_dz   = 1'b0;
    m_res  = '0;
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic void model(input bit is_div, input bit sgn, input logic [31:0] a,
                                input logic [15:0] b, output logic [31:0] res,
                                output logic [15:0] rem, output int lat);
    longint x, y, q, r;
    if (!is_div) begin
      x   = sgn ? {{48{a[15]}}, a[15:0]} : {48'b0, a[15:0]};
      y   = sgn ? {{48{b[15]}}, b} : {48'b0, b};
      q   = x * y;
      res = q[31:0];
      rem = '0;
      lat = sgn ? W + 2 : W;
    end else if (b == 16'h0) begin
      res = '0;
      rem = a[15:0];
      lat = 1;
    end else begin
      x   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      y   = sgn ? {{48{b[15]}}, b} : {48'b0, b};
      q   = x / y;
      r   = x % y;
      res = q[31:0];
      rem = r[15:0];
      lat = sgn ? 2 * W + 2 : 2 * W;
    end
  endfunction

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [15:0] b,
                        input string tag);
    logic [31:0] e_res, g;
    logic [15:0] e_rem;
    logic [7:0]  st;
    int          lat, cyc, d0;
    model(is_div, m_mode, a, b, e_res, e_rem, lat);
    for (int i = 0; i < 4; i++) bus_wr(i, a[8*i +: 8]);
    bus_wr(is_div ? 6 : 4, b[7:0]);
    d0 = n_done;
    bus_wr(is_div ? 7 : 5, b[15:8]);
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    rd_bytes(8, 4, g);
    chk({tag, "_res"}, g, e_res);
    rd_bytes(12, 2, g);
    chk({tag, "_rem"}, g, 32'(e_rem));
    if (is_div) m_dz = (b == 16'h0);
    bus_rd(15, st);
    chk({tag, "_status"}, 32'(st), 32'({6'b0, m_dz, m_mode}));
    chk({tag, "_ndone"}, n_done - d0, 1);
    m_res = e_res;
  endtask

  initial begin
    logic [31:0] g, e_res;
    logic [15:0] e_rem, rb;
    logic [7:0]  b8;
    logic [31:0] ra;
    bit          rd_op;
    int          cyc, d0, lat, sel;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    rd_bytes(8, 4, g);
    chk("rst_res", g, 32'd0);
    bus_rd(15, b8);
    chk("rst_status", 32'(b8), 32'd0);

    run_op(1'b0, 32'h0000FFFF, 16'hFFFF, "umul");
    set_mode(1'b1);
    run_op(1'b0, 32'h0000FFFF, 16'h0002, "smul");
    set_mode(1'b0);
    run_op(1'b0, 32'h0000FFFF, 16'h0002, "umul2");
    run_op(1'b1, 32'h000186A0, 16'h0007, "udiv");
    set_mode(1'b1);
    run_op(1'b1, 32'hFFFFFFF9, 16'h0002, "sdiv");
    run_op(1'b1, 32'h80000000, 16'hFFFF, "sdiv_wrap");
    run_op(1'b1, 32'h12345678, 16'h0000, "sdz");
    set_mode(1'b0);
    run_op(1'b1, 32'h12345678, 16'h0000, "dz");
    run_op(1'b1, 32'h12345678, 16'h0003, "dz_clear");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)));
      rd_op = 1'($urandom_range(0, 1));
      ra    = $urandom;
      rb    = 16'($urandom);
      sel   = int'($urandom_range(0, 9));
      if (sel == 0) rb = 16'h0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 16'hFFFF; end
      else if (sel == 2) rb = 16'h0001;
      run_op(rd_op, ra, rb, $sformatf("rnd%0d", k));
    end

    // Divide aborted by a multiply restart; old result visible while busy
    set_mode(1'b0);
    run_op(1'b0, 32'h00001234, 16'h0010, "pre");
    for (int i = 0; i < 4; i++) bus_wr(i, 8'(32'h00ABCDEF >> (8 * i)));
    bus_wr(6, 8'h03);
    d0 = n_done;
    bus_wr(7, 8'h00);
    bus_rd(8, b8);
    chk("busy_read_res", 32'(b8), 32'(m_res[7:0]));
    bus_wr(4, 8'h21);
    repeat (2) @(posedge CLK);
    bus_wr(5, 8'h43);
    wait_done(cyc);
    chk("restart_lat", cyc, W);
    model(1'b0, 1'b0, 32'h00ABCDEF, 16'h4321, e_res, e_rem, lat);
    rd_bytes(8, 4, g);
    chk("restart_res", g, e_res);
    chk("restart_ndone", n_done - d0, 1);

    // Restart landing on the completion edge
    bus_wr(4, 8'h05);
    d0 = n_done;
    bus_wr(5, 8'h00);
    repeat (W - 1) @(posedge CLK);
    bus_wr(5, 8'h07);
    chk("edge_restart_busy", 32'(BUSY), 32'd1);
    chk("edge_restart_done", 32'(DONE), 32'd0);
    wait_done(cyc);
    chk("edge_restart_lat", cyc, W);
    model(1'b0, 1'b0, 32'h00ABCDEF, 16'h0705, e_res, e_rem, lat);
    rd_bytes(8, 4, g);
    chk("edge_restart_res", g, e_res);
    chk("edge_restart_ndone", n_done - d0, 1);

    // CTRL write mid-divide
    d0 = n_done;
    bus_wr(6, 8'h09);
    bus_wr(7, 8'h00);
    repeat (3) @(posedge CLK);
    bus_wr(14, 8'h00);
    m_mode = 1'b0; m_dz = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_ndone", n_done - d0, 0);
    rd_bytes(8, 4, g);
    chk("abort_res", g, 32'd0);
    rd_bytes(12, 2, g);
    chk("abort_rem", g, 32'd0);
    rd_bytes(0, 4, g);
    chk("abort_a", g, 32'd0);

    // Same-cycle read and write of one address returns the old value
    bus_wr(0, 8'h11);
    @(negedge CLK);
    EN = 1'b1; RD = 1'b1; WR = 1'b1; ADDR = '0; DIN = 8'h5A;
    @(posedge CLK); #1;
    EN = 1'b0; RD = 1'b0; WR = 1'b0;
    chk("rdwr_old", 32'(DOUT), 32'h11);
    bus_rd(0, b8);
    chk("rdwr_new", 32'(b8), 32'h5A);
    bus_rd(16, b8);
    chk("unmapped16", 32'(b8), 32'd0);
    bus_rd(31, b8);
    chk("unmapped31", 32'(b8), 32'd0);

    // Asynchronous reset in the middle of a signed divide
    set_mode(1'b1);
    for (int i = 0; i < 4; i++) bus_wr(i, 8'(32'hDEADBEEF >> (8 * i)));
    bus_wr(6, 8'h07);
    bus_wr(7, 8'h00);
    repeat (4) @(posedge CLK);
    bus_rd(0, b8);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_dout", 32'(DOUT), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    m_mode = 1'b0; m_dz = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_rd(i, b8);
      chk($sformatf("arst_reg%0d", i), 32'(b8), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
